// File: rtl/truth_sweep_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package truth_sweep_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StCheck,
    StDone
  } sweep_state_e;

  // Counter width that covers hold lengths up to 15 cycles.
  localparam int unsigned SettleCntW = 4;

  // Bit offset of a vector's expected-output slice within the packed golden table.
  function automatic int unsigned slice_base(input int unsigned vec, input int unsigned width);
    return vec * width;
  endfunction

endpackage

// File: rtl/sweep_settle_cnt.sv
// Hold-cycle down-counter: loaded when a vector is first applied, ticks while the
// vector is held, and flags expiry once the hold has lasted long enough.
module sweep_settle_cnt
  import truth_sweep_pkg::*;
#(
  parameter logic [SettleCntW-1:0] LoadVal = '0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_tick,
  output logic o_expire
);

  logic [SettleCntW-1:0] r_cnt;

  // Count down from LoadVal; saturate at zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LoadVal;
    end else if (i_tick && (r_cnt != '0)) begin
      r_cnt <= r_cnt - SettleCntW'(1);
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: walks dut_in through every input vector in ascending order,
// holds each for SETTLE+1 cycles, compares dut_out against a golden table in the
// last hold cycle and counts mismatches.
// Optional feature: define FIRST_FAIL_CAPTURE_EN to add fail_valid/fail_vec, which
// record the index of the first mismatching vector of a sweep.
module truth_table_sweeper
  import truth_sweep_pkg::*;
#(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned N_OUT  = 1,
  parameter int unsigned SETTLE = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [N_OUT*(2**N_IN)-1:0]  expected,
  output logic [N_IN-1:0]             dut_in,
  input  logic [N_OUT-1:0]            dut_out,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
`ifdef FIRST_FAIL_CAPTURE_EN
  output logic                        fail_valid,
  output logic [N_IN-1:0]             fail_vec,
`endif
  output logic [N_IN:0]               err_cnt
);

  // HOLD lasts SETTLE cycles, so the counter starts at SETTLE-1 and expires at zero.
  localparam logic [SettleCntW-1:0] SettleLoad =
      (SETTLE == 0) ? '0 : SettleCntW'(SETTLE - 1);
  localparam logic [N_IN-1:0] VecOne = N_IN'(1);
  localparam logic [N_IN:0]   ErrOne = (N_IN + 1)'(1);

  sweep_state_e r_state, w_state_d;

  logic [N_IN-1:0]  r_vec;
  logic [N_IN:0]    r_err;
  logic             r_pass;
  logic             r_done;
  logic             w_accept;
  logic             w_load;
  logic             w_tick;
  logic             w_expire;
  logic             w_cmp_en;
  logic             w_advance;
  logic             w_last;
  logic             w_mismatch;
  logic [N_OUT-1:0] w_golden;

  sweep_settle_cnt #(
    .LoadVal (SettleLoad)
  ) u_settle_cnt (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_load   (w_load),
    .i_tick   (w_tick),
    .o_expire (w_expire)
  );

  assign w_last     = (r_vec == '1);
  assign w_golden   = expected[slice_base(32'(r_vec), N_OUT) +: N_OUT];
  assign w_mismatch = (dut_out != w_golden);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state and control decode; with SETTLE=0 the HOLD state is skipped entirely.
  always_comb begin
    w_state_d = r_state;
    w_accept  = 1'b0;
    w_load    = 1'b0;
    w_tick    = 1'b0;
    w_cmp_en  = 1'b0;
    w_advance = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_accept = 1'b1;
          if (SETTLE == 0) begin
            w_state_d = StCheck;
          end else begin
            w_state_d = StHold;
            w_load    = 1'b1;
          end
        end
      end
      StHold: begin
        w_tick = 1'b1;
        if (w_expire) begin
          w_state_d = StCheck;
        end
      end
      StCheck: begin
        w_cmp_en = 1'b1;
        if (w_last) begin
          w_state_d = StDone;
        end else begin
          w_advance = 1'b1;
          if (SETTLE != 0) begin
            w_state_d = StHold;
            w_load    = 1'b1;
          end
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Vector, error count, verdict and done pulse. err_cnt cannot wrap: its width
  // holds 2^N_IN and at most one mismatch is counted per vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec  <= '0;
      r_err  <= '0;
      r_pass <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == StDone);
      if (w_accept) begin
        r_vec  <= '0;
        r_err  <= '0;
        r_pass <= 1'b0;
      end else begin
        if (w_cmp_en && w_mismatch) begin
          r_err <= r_err + ErrOne;
        end
        if (w_advance) begin
          r_vec <= r_vec + VecOne;
        end
        if (r_state == StDone) begin
          r_pass <= (r_err == '0);
        end
      end
    end
  end

`ifdef FIRST_FAIL_CAPTURE_EN
  logic            r_fail_valid;
  logic [N_IN-1:0] r_fail_vec;

  // Latch the index of the first mismatch of the sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fail_valid <= 1'b0;
      r_fail_vec   <= '0;
    end else if (w_accept) begin
      r_fail_valid <= 1'b0;
      r_fail_vec   <= '0;
    end else if (w_cmp_en && w_mismatch && !r_fail_valid) begin
      r_fail_valid <= 1'b1;
      r_fail_vec   <= r_vec;
    end
  end

  assign fail_valid = r_fail_valid;
  assign fail_vec   = r_fail_vec;
`endif

  assign dut_in  = r_vec;
  assign err_cnt = r_err;
  assign pass    = r_pass;
  assign done    = r_done;
  assign busy    = (r_state == StHold) || (r_state == StCheck);

endmodule
